// File: rtl/dmx_pkg.sv
// Shared types, word-format constants and default timing for the DMX512 transmitter.
package dmx_pkg;

    typedef enum logic [2:0] {StIdle, StBreak, StMab, StSlot, StMtbp} dmx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 2;
    localparam int unsigned WORD_BITS = 1 + DATA_BITS + STOP_BITS;

    localparam int unsigned DEF_CLOCK_HZ   = 12_000_000;
    localparam int unsigned DEF_BAUD       = 250_000;
    localparam int unsigned DEF_BREAK_BITS = 44;
    localparam int unsigned DEF_MAB_BITS   = 3;
    localparam int unsigned DEF_MTBP_BITS  = 0;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned bit_div(input int unsigned clock_hz, input int unsigned baud);
        return (clock_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/dmx_universe_tx.sv
// Single-universe DMX512 transmitter: frame FSM, bit timer, double-buffered slot RAM.
// Optional DMX_BLACKOUT_EN adds a blackout input that zeroes data slots at capture.
module dmx_universe_tx
    import dmx_pkg::*;
#(
    parameter int unsigned BIT_DIV    = 48,
    parameter int unsigned SLOTS      = 512,
    parameter int unsigned BREAK_BITS = DEF_BREAK_BITS,
    parameter int unsigned MAB_BITS   = DEF_MAB_BITS,
    parameter int unsigned MTBP_BITS  = DEF_MTBP_BITS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [9:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
`ifdef DMX_BLACKOUT_EN
    input  logic       blackout,
`endif
    output logic       commit_pending,
    output logic       frame_done,
    output logic       dmx,
    output logic       dmx_de
);

    localparam int unsigned TW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int unsigned AW = $clog2(SLOTS + 1);
    localparam int unsigned CW = 16;

    dmx_state_e           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        slot_q, slot_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 bank_q, bank_d;
    logic                 pend_q, pend_d;
    logic                 done_q, done_d;
    logic                 line_q, line_d;
    logic                 de_q, de_d;

    logic                 tick, load, frame_end, swap;
    logic [AW-1:0]        rd_slot;
    logic [DATA_BITS-1:0] rd_byte;
    logic [DATA_BITS-1:0] mem [2][SLOTS+1];

    always_ff @(posedge clock) begin
        if (wr_en && wr_addr <= 10'(SLOTS)) begin
            mem[~bank_q][wr_addr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            shift_q <= '1;
            bank_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            line_q  <= 1'b1;
            de_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            shift_q <= shift_d;
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            line_q  <= line_d;
            de_q    <= de_d;
        end
    end

    always_comb begin
        tick      = (timer_q == TW'(BIT_DIV - 1));
        state_d   = state_q;
        timer_d   = tick ? '0 : timer_q + TW'(1);
        cnt_d     = tick ? cnt_q + CW'(1) : cnt_q;
        slot_d    = slot_q;
        shift_d   = tick ? {1'b1, shift_q[WORD_BITS-1:1]} : shift_q;
        load      = 1'b0;
        frame_end = 1'b0;
        // Next slot to capture: start code on leaving MAB, else the following slot.
        rd_slot   = (state_q == StSlot) ? slot_q + AW'(1) : '0;
        rd_byte   = mem[bank_q][rd_slot];
`ifdef DMX_BLACKOUT_EN
        if (blackout && rd_slot != '0) begin
            rd_byte = '0;
        end
`endif
        case (state_q)
            StIdle: begin
                timer_d = '0;
                cnt_d   = '0;
                if (enable) begin
                    state_d = StBreak;
                end
            end
            StBreak: begin
                if (tick && cnt_q == CW'(BREAK_BITS - 1)) begin
                    state_d = StMab;
                    cnt_d   = '0;
                end
            end
            StMab: begin
                if (tick && cnt_q == CW'(MAB_BITS - 1)) begin
                    state_d = StSlot;
                    cnt_d   = '0;
                    slot_d  = '0;
                    load    = 1'b1;
                end
            end
            StSlot: begin
                if (tick && cnt_q == CW'(WORD_BITS - 1)) begin
                    cnt_d = '0;
                    if (slot_q == AW'(SLOTS)) begin
                        frame_end = 1'b1;
                        if (MTBP_BITS > 0) begin
                            state_d = StMtbp;
                        end else begin
                            state_d = enable ? StBreak : StIdle;
                        end
                    end else begin
                        slot_d = rd_slot;
                        load   = 1'b1;
                    end
                end
            end
            StMtbp: begin
                if (tick && cnt_q == CW'(MTBP_BITS - 1)) begin
                    state_d = enable ? StBreak : StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            shift_d = {{STOP_BITS{1'b1}}, rd_byte, 1'b0};
        end
        swap   = frame_end && (pend_q || commit);
        pend_d = swap ? 1'b0 : (pend_q || commit);
        bank_d = bank_q ^ swap;
        done_d = frame_end;
    end

    // Line levels are decoded from the next state so they register alongside it.
    always_comb begin
        line_d = 1'b1;
        de_d   = 1'b1;
        case (state_d)
            StIdle:  de_d   = 1'b0;
            StBreak: line_d = 1'b0;
            StSlot:  line_d = shift_d[0];
            default: line_d = 1'b1;
        endcase
    end

    assign commit_pending = pend_q;
    assign frame_done     = done_q;
    assign dmx            = line_q;
    assign dmx_de         = de_q;

endmodule

// File: rtl/dmx_multi_tx.sv
// Multi-universe DMX512 transmitter: one dmx_universe_tx per output plus write-port decode.
// Define DMX_BLACKOUT_EN to add the global blackout input.
module dmx_multi_tx
    import dmx_pkg::*;
#(
    parameter int unsigned CLOCK_HZ   = DEF_CLOCK_HZ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned UNIVERSES  = 2,
    parameter int unsigned SLOTS      = 512,
    parameter int unsigned BREAK_BITS = DEF_BREAK_BITS,
    parameter int unsigned MAB_BITS   = DEF_MAB_BITS,
    parameter int unsigned MTBP_BITS  = DEF_MTBP_BITS,
    localparam int unsigned UW        = (UNIVERSES > 1) ? $clog2(UNIVERSES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [UNIVERSES-1:0] enable,
    input  logic                 wr_en,
    input  logic [UW-1:0]        wr_universe,
    input  logic [9:0]           wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [UNIVERSES-1:0] commit,
`ifdef DMX_BLACKOUT_EN
    input  logic                 blackout,
`endif
    output logic [UNIVERSES-1:0] commit_pending,
    output logic [UNIVERSES-1:0] frame_done,
    output logic [UNIVERSES-1:0] dmx,
    output logic [UNIVERSES-1:0] dmx_n,
    output logic [UNIVERSES-1:0] dmx_de
);

    localparam int unsigned BIT_DIV = bit_div(CLOCK_HZ, BAUD);

    for (genvar u = 0; u < UNIVERSES; u++) begin : g_universe
        // Out-of-range universe numbers match no instance and are dropped.
        logic wr_hit;
        assign wr_hit = wr_en && (wr_universe == UW'(u));

        dmx_universe_tx #(
            .BIT_DIV    (BIT_DIV),
            .SLOTS      (SLOTS),
            .BREAK_BITS (BREAK_BITS),
            .MAB_BITS   (MAB_BITS),
            .MTBP_BITS  (MTBP_BITS)
        ) u_tx (
            .clock          (clock),
            .reset          (reset),
            .enable         (enable[u]),
            .wr_en          (wr_hit),
            .wr_addr        (wr_addr),
            .wr_data        (wr_data),
            .commit         (commit[u]),
`ifdef DMX_BLACKOUT_EN
            .blackout       (blackout),
`endif
            .commit_pending (commit_pending[u]),
            .frame_done     (frame_done[u]),
            .dmx            (dmx[u]),
            .dmx_de         (dmx_de[u])
        );
    end

    assign dmx_n = ~dmx;

endmodule

// File: tb/tb_dmx_multi_tx.sv
// Bench for dmx_multi_tx: line receiver per universe checked against a bank/commit model.
module tb_dmx_multi_tx;

    localparam int U       = 3;
    localparam int SLOTS   = 4;
    localparam int BIT_DIV = 48;
    localparam int HALF    = BIT_DIV / 2;
    localparam int BRK_CLK = 44 * BIT_DIV;
    localparam int MAB_CLK = 3 * BIT_DIV;
    localparam int WRD_CLK = 11 * BIT_DIV;

    logic         clock;
    logic         reset;
    logic [U-1:0] enable;
    logic         wr_en;
    logic [1:0]   wr_universe;
    logic [9:0]   wr_addr;
    logic [7:0]   wr_data;
    logic [U-1:0] commit;
    logic [U-1:0] commit_pending;
    logic [U-1:0] frame_done;
    logic [U-1:0] dmx;
    logic [U-1:0] dmx_n;
    logic [U-1:0] dmx_de;
`ifdef DMX_BLACKOUT_EN
    logic         blackout;
`endif

    dmx_multi_tx #(
        .UNIVERSES (U),
        .SLOTS     (SLOTS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .wr_en          (wr_en),
        .wr_universe    (wr_universe),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
`ifdef DMX_BLACKOUT_EN
        .blackout       (blackout),
`endif
        .commit_pending (commit_pending),
        .frame_done     (frame_done),
        .dmx            (dmx),
        .dmx_n          (dmx_n),
        .dmx_de         (dmx_de)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: two banks per universe, active select, pending commit.
    logic [7:0] mem_m   [U][2][SLOTS+1];
    bit         known_m [U][2];
    bit         act_m   [U];
    bit         pend_m  [U];
    bit         bo_m;

    int          rx_brk  [U];
    int          rx_mab  [U];
    logic [10:0] rx_word [U][SLOTS+1];
    logic        rx_fd_early [U];
    logic        rx_fd   [U];
    logic        rx_pend [U];
    logic        rx_de   [U];
    logic        rx_line [U];
    logic        rx_en   [U];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int u, input int w);
        if (bo_m && w != 0) return 8'h00;
        return mem_m[u][act_m[u]][w];
    endfunction

    task automatic host_wr(input int u, input int a, input logic [7:0] d);
        @(negedge clock);
        wr_en = 1'b1;
        wr_universe = 2'(u);
        wr_addr = 10'(a);
        wr_data = d;
        @(negedge clock);
        wr_en = 1'b0;
        if (u < U && a <= SLOTS) begin
            mem_m[u][act_m[u] ? 0 : 1][a] = d;
            known_m[u][act_m[u] ? 0 : 1] = 1'b1;
        end
    endtask

    task automatic wr_bank(input int u, input logic [39:0] v);
        for (int i = 0; i <= SLOTS; i++) host_wr(u, i, v[8*i +: 8]);
    endtask

    task automatic host_commit(input int u);
        @(negedge clock);
        commit[u] = 1'b1;
        @(negedge clock);
        commit[u] = 1'b0;
        pend_m[u] = 1'b1;
    endtask

    // Receives one frame, starting at or before its BREAK; returns at the cycle after the
    // last stop bit.
    task automatic rx_frame(input int u);
        int t;
        logic [10:0] w;
        t = 0;
        while (dmx[u] !== 1'b0 && t < 20000) begin
            @(negedge clock);
            t++;
        end
        check($sformatf("u%0d_rx_break_seen", u), dmx[u], 1'b0);
        if (dmx[u] !== 1'b0) return;
        rx_brk[u] = 0;
        while (dmx[u] === 1'b0 && rx_brk[u] < 5000) begin
            rx_brk[u]++;
            @(negedge clock);
        end
        rx_mab[u] = 0;
        while (dmx[u] === 1'b1 && rx_mab[u] < 5000) begin
            rx_mab[u]++;
            @(negedge clock);
        end
        for (int wi = 0; wi <= SLOTS; wi++) begin
            repeat (HALF) @(negedge clock);
            for (int b = 0; b < 11; b++) begin
                w[b] = dmx[u];
                if (b < 10) repeat (BIT_DIV) @(negedge clock);
            end
            rx_word[u][wi] = w;
            if (wi == SLOTS) begin
                rx_fd_early[u] = frame_done[u];
                rx_en[u] = enable[u];
            end
            repeat (BIT_DIV - HALF) @(negedge clock);
        end
        rx_fd[u]   = frame_done[u];
        rx_pend[u] = commit_pending[u];
        rx_de[u]   = dmx_de[u];
        rx_line[u] = dmx[u];
    endtask

    task automatic finish_frame(input int u, input string name);
        if (known_m[u][act_m[u]]) begin
            for (int w = 0; w <= SLOTS; w++) begin
                check($sformatf("%s_word%0d", name, w), rx_word[u][w],
                      {21'd0, 2'b11, exp_byte(u, w), 1'b0});
            end
        end
        check({name, "_break_clks"}, rx_brk[u], BRK_CLK);
        check({name, "_mab_clks"}, rx_mab[u], MAB_CLK);
        check({name, "_done_early"}, rx_fd_early[u], 1'b0);
        check({name, "_done"}, rx_fd[u], 1'b1);
        if (pend_m[u]) begin
            act_m[u]  = !act_m[u];
            pend_m[u] = 1'b0;
        end
        check({name, "_pending"}, rx_pend[u], pend_m[u]);
        check({name, "_de_after"}, rx_de[u], rx_en[u]);
        check({name, "_line_after"}, rx_line[u], !rx_en[u]);
    endtask

    task automatic idle_check(input int u, input int n, input string name);
        int lows;
        int fds;
        lows = 0;
        fds = 0;
        repeat (n) begin
            @(negedge clock);
            if (dmx[u] !== 1'b1) lows++;
            if (frame_done[u] !== 1'b0) fds++;
        end
        check({name, "_low_clks"}, lows, 0);
        check({name, "_done_pulses"}, fds, 0);
        check({name, "_de"}, dmx_de[u], 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        enable = '0;
        commit = '0;
        wr_en = 1'b0;
        wr_universe = '0;
        wr_addr = '0;
        wr_data = '0;
        bo_m = 1'b0;
`ifdef DMX_BLACKOUT_EN
        blackout = 1'b0;
`endif
        for (int u = 0; u < U; u++) begin
            act_m[u] = 1'b0;
            pend_m[u] = 1'b0;
            known_m[u][0] = 1'b0;
            known_m[u][1] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check("rst_dmx", dmx, 3'b111);
        check("rst_dmx_n", dmx_n, 3'b000);
        check("rst_de", dmx_de, 3'b000);
        check("rst_done", frame_done, 3'b000);
        check("rst_pending", commit_pending, 3'b000);
        reset = 1'b0;
        @(negedge clock);

        wr_bank(0, 40'h44_33_22_11_00);
        wr_bank(1, 40'hD4_C3_B2_A1_00);
        host_wr(1, 5, 8'hEE);
        host_wr(1, 513, 8'hEE);
        host_wr(3, 2, 8'h5A);
        host_commit(0);
        host_commit(1);
        check("pending_after_commit", commit_pending, 3'b011);

        enable[0] = 1'b1;
        @(negedge clock);
        check("u0_break_start", dmx[0], 1'b0);
        check("u0_de_start", dmx_de[0], 1'b1);
        check("u0_dmx_n_start", dmx_n[0], 1'b1);

        fork
            begin
                rx_frame(0);
                finish_frame(0, "u0_f1");
                fork
                    rx_frame(0);
                    begin
                        repeat (3000) @(negedge clock);
                        wr_bank(0, 40'h44_33_22_AA_00);
                    end
                join
                finish_frame(0, "u0_f2");
                fork
                    rx_frame(0);
                    begin
                        repeat (MAB_CLK + BRK_CLK + WRD_CLK + 100) @(negedge clock);
                        host_commit(0);
                    end
                join
                finish_frame(0, "u0_f3");
                fork
                    rx_frame(0);
                    begin
                        repeat (MAB_CLK + BRK_CLK + WRD_CLK + 100) @(negedge clock);
                        enable[0] = 1'b0;
                    end
                join
                finish_frame(0, "u0_f4");
                idle_check(0, 3000, "u0_idle");
            end
            begin
                repeat (777) @(negedge clock);
                enable[1] = 1'b1;
                @(negedge clock);
                check("u1_break_start", dmx[1], 1'b0);
                check("u1_de_start", dmx_de[1], 1'b1);
                rx_frame(1);
                finish_frame(1, "u1_f1");
                fork
                    rx_frame(1);
                    begin
                        repeat (MAB_CLK + BRK_CLK + 100) @(negedge clock);
                        enable[1] = 1'b0;
                    end
                join
                finish_frame(1, "u1_f2");
                idle_check(1, 200, "u1_idle");
            end
        join

`ifdef DMX_BLACKOUT_EN
        blackout = 1'b1;
        bo_m = 1'b1;
`endif
        enable[0] = 1'b1;
        @(negedge clock);
        check("u0_restart_break", dmx[0], 1'b0);
        fork
            rx_frame(0);
            begin
                repeat (3000) @(negedge clock);
                host_commit(0);
            end
        join
        finish_frame(0, "u0_f5");
`ifdef DMX_BLACKOUT_EN
        blackout = 1'b0;
`endif
        bo_m = 1'b0;

        repeat (BRK_CLK + MAB_CLK + 2 * WRD_CLK + 200) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_dmx", dmx[0], 1'b1);
        check("rst_mid_dmx_n", dmx_n[0], 1'b0);
        check("rst_mid_de", dmx_de[0], 1'b0);
        check("rst_mid_pending", commit_pending, 3'b000);
        for (int u = 0; u < U; u++) begin
            act_m[u] = 1'b0;
            pend_m[u] = 1'b0;
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_rel_break", dmx[0], 1'b0);
        check("rst_rel_de", dmx_de[0], 1'b1);
        rx_frame(0);
        finish_frame(0, "u0_f6");
        enable[0] = 1'b0;
        check("u2_never_dmx", dmx[2], 1'b1);
        check("u2_never_de", dmx_de[2], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
